// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// It handles MULT/MULTU (shift-add) and DIV/DIVU (restoring), plus MTHI/MTLO writes.
//
// state  | meaning
// IDLE   | waiting for Start; MTHI/MTLO writes honoured
// CALC   | one shift-add / restoring-divide iteration per clock
// FINISH | sign correction, HI/LO update, Done pulse
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             Flush,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_a_q, neg_a_d;
    logic                 neg_b_q, neg_b_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     addend_q, addend_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 div0_q, div0_d;

    logic                 start_ok;
    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign start_ok  = (state_q == S_IDLE) && Start && !Flush;
    assign signed_op = !Op[0];
    assign a_mag     = (signed_op && OperandA[WIDTH-1]) ? (~OperandA + 1'b1) : OperandA;
    assign b_mag     = (signed_op && OperandB[WIDTH-1]) ? (~OperandB + 1'b1) : OperandB;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush outranks everything, including FINISH and a coincident Start.
    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   if (Start) state_d = S_CALC;
                S_CALC:   if (cnt_q == CW'(ITER - 1)) state_d = S_FINISH;
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        Busy   = (state_q != S_IDLE);
        done_d = (state_q == S_FINISH) && !Flush;
        div0_d = (state_q == S_FINISH) && !Flush && dbz_q;
    end

    // Multiply keeps the multiplier in the low half and shifts right;
    // divide keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, addend_q} : '0);
        div_trial = prod_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, addend_q};
        prod_neg  = ~prod_q + 1'b1;
        quo_fix   = (neg_a_q ^ neg_b_q) ? (~prod_q[WIDTH-1:0] + 1'b1) : prod_q[WIDTH-1:0];
        rem_fix   = neg_a_q ? (~prod_q[2*WIDTH-1:WIDTH] + 1'b1) : prod_q[2*WIDTH-1:WIDTH];

        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dbz_d    = dbz_q;
        addend_d = addend_q;
        prod_d   = prod_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (state_q == S_IDLE) begin
            if (HiWrite) hi_d = WriteData;
            if (LoWrite) lo_d = WriteData;
        end

        if (start_ok) begin
            op_d     = Op;
            neg_a_d  = signed_op && OperandA[WIDTH-1];
            neg_b_d  = signed_op && OperandB[WIDTH-1];
            dbz_d    = Op[1] && (OperandB == '0);
            cnt_d    = '0;
            addend_d = Op[1] ? b_mag : a_mag;
            prod_d   = Op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
        end else if (state_q == S_CALC && !Flush) begin
            cnt_d = cnt_q + CW'(1);
            if (!op_q[1]) begin
                prod_d = {mul_sum, prod_q[WIDTH-1:1]};
            end else if (!div_diff[WIDTH]) begin
                prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
            end else begin
                prod_d = {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
            end
        end else if (state_q == S_FINISH && !Flush && !dbz_q) begin
            if (!op_q[1]) begin
                {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : prod_q;
            end else begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dbz_q    <= 1'b0;
            addend_q <= '0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dbz_q    <= dbz_d;
            addend_q <= addend_d;
            prod_q   <= prod_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    assign Done      = done_q;
    assign DivByZero = div0_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: issued operations push expected HI/LO/flag and
// completion edge into a queue; a negedge monitor pops and checks on every Done.
module tb_mult_div_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OperandA, OperandB;
    logic        Flush, HiWrite, LoWrite;
    logic [31:0] WriteData;
    logic        Busy, Done, DivByZero;
    logic [31:0] Hi, Lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          edge_n;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   edge_cnt   = 0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (DivByZero && !Done) check("dbz_without_done", 64'(DivByZero), 64'(0));
            if (Done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(Done), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("hi", 64'(Hi), 64'(e.hi));
                    check("lo", 64'(Lo), 64'(e.lo));
                    check("div_by_zero", 64'(DivByZero), 64'(e.dbz));
                    check("latency_edge", 64'(edge_cnt), 64'(e.edge_n));
                    check("busy_at_done", 64'(Busy), 64'(0));
                end
            end
        end
    end

    // Called between edges; the Start is sampled at the next rising edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                         input bit push);
        exp_t e;
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        if (push) begin
            e.hi = ehi; e.lo = elo; e.dbz = edbz; e.edge_n = edge_cnt + 34;
            exp_q.push_back(e);
        end
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge Clk);
            if (Done) seen = 1;
        end
        if (!seen) begin
            compared++; mismatched++;
            $display("FAIL %s_timeout: no Done within 50 cycles, expected one", name);
        end
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
        Flush = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
        repeat (3) @(negedge Clk);
        check("reset_busy", 64'(Busy), 64'(0));
        check("reset_done", 64'(Done), 64'(0));
        check("reset_hi", 64'(Hi), 64'(0));
        check("reset_lo", 64'(Lo), 64'(0));
        Reset_n = 1'b1;
        @(negedge Clk);

        // MULT -3 * 7 with Busy window checks
        issue(2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1);
        @(negedge Clk);
        check("mult_busy_first", 64'(Busy), 64'(1));
        repeat (32) @(negedge Clk);
        check("mult_busy_last", 64'(Busy), 64'(1));
        check("mult_no_early_done", 64'(Done), 64'(0));
        wait_done("mult");

        // MULTU launched while Done is high; repeated Start at cycle 10 ignored
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1);
        repeat (9) @(negedge Clk);
        Start = 1'b1; OperandA = 32'd1;
        @(posedge Clk); #1;
        Start = 1'b0;
        wait_done("multu");

        @(negedge Clk);
        issue(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1);
        wait_done("div");
        @(negedge Clk);
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1);
        wait_done("divu");
        @(negedge Clk);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1);
        wait_done("div_overflow");

        // Preload then divide by zero
        @(negedge Clk);
        HiWrite = 1'b1; WriteData = 32'h11111111;
        @(negedge Clk);
        HiWrite = 1'b0; LoWrite = 1'b1; WriteData = 32'h22222222;
        @(negedge Clk);
        LoWrite = 1'b0;
        check("preload_hi", 64'(Hi), 64'h11111111);
        check("preload_lo", 64'(Lo), 64'h22222222);
        issue(2'b11, 32'd100, 32'd0, 32'h11111111, 32'h22222222, 1'b1, 1);
        wait_done("divu_zero");

        // Flush at cycle 5 of MULT
        @(negedge Clk);
        issue(2'b00, 32'd3, 32'd5, '0, '0, 1'b0, 0);
        repeat (4) @(negedge Clk);
        Flush = 1'b1;
        @(posedge Clk); #1;
        Flush = 1'b0;
        @(negedge Clk);
        check("flush_busy", 64'(Busy), 64'(0));
        repeat (40) @(negedge Clk);
        check("flush_hi", 64'(Hi), 64'h11111111);
        check("flush_lo", 64'(Lo), 64'h22222222);

        // HiWrite while busy is ignored
        issue(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1);
        @(negedge Clk);
        HiWrite = 1'b1; WriteData = 32'hAAAAAAAA;
        @(posedge Clk); #1;
        HiWrite = 1'b0;
        @(negedge Clk);
        check("busy_hiwrite_ignored", 64'(Hi), 64'h11111111);
        wait_done("multu_small");

        // MTLO while idle
        @(negedge Clk);
        LoWrite = 1'b1; WriteData = 32'hDEADBEEF;
        @(posedge Clk); #1;
        LoWrite = 1'b0;
        check("mtlo_lo", 64'(Lo), 64'hDEADBEEF);
        check("mtlo_hi_kept", 64'(Hi), 64'h0);

        // Async reset mid-CALC
        @(negedge Clk);
        issue(2'b00, 32'd9, 32'd9, '0, '0, 1'b0, 0);
        repeat (10) @(negedge Clk);
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        #1;
        check("midreset_busy", 64'(Busy), 64'(0));
        check("midreset_done", 64'(Done), 64'(0));
        check("midreset_hi", 64'(Hi), 64'(0));
        check("midreset_lo", 64'(Lo), 64'(0));
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (40) @(negedge Clk);
        check("postreset_busy", 64'(Busy), 64'(0));

        check("pending_expectations", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
